// File: rtl/mont_arbiter.sv
// mont_arbiter: shares a single Montgomery multiplier among NUM_REQ requesters.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// The default build uses round-robin arbitration.
// If MONT_ARB_FIXED_PRIO_EN is defined, arbitration is fixed priority instead:
// the lowest index wins, and there is no rr_ptr.
module mont_arbiter #(
    parameter int unsigned  MOD_WIDTH = 256,
    parameter int unsigned  NUM_REQ   = 2,
    localparam int unsigned IDW       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*MOD_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*MOD_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*MOD_WIDTH-1:0] req_modulus,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [MOD_WIDTH-1:0]         rsp_data,
    output logic                         mont_i_valid,
    input  logic                         mont_i_ready,
    output logic [3*MOD_WIDTH-1:0]       mont_i_data,
    input  logic                         mont_o_valid,
    output logic                         mont_o_ready,
    input  logic [MOD_WIDTH-1:0]         mont_o_data,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e               state_q;
    logic [IDW-1:0]       grant_id_q;
    logic [MOD_WIDTH-1:0] op_a_q;
    logic [MOD_WIDTH-1:0] op_b_q;
    logic [MOD_WIDTH-1:0] op_m_q;
    logic [MOD_WIDTH-1:0] rsp_q;
    logic                 win_valid;
    logic [IDW-1:0]       win_idx;

`ifndef MONT_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr_q;

    // base + off modulo NUM_REQ; both operands are below NUM_REQ, so one subtraction suffices
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                                input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDW'(sum);
    endfunction
`endif

    // Winner selection; scan runs backwards so the last hit is the highest-priority one
    always_comb begin
        win_valid = |req_valid;
        win_idx   = '0;
`ifdef MONT_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) win_idx = IDW'(i);
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(rr_ptr_q, k)]) win_idx = rr_index(rr_ptr_q, k);
        end
`endif
    end

    // Per-requester handshakes decoded from the registered state.
    // rst_n gating keeps req_ready low while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == StIdle && win_valid && rst_n) req_ready[win_idx] = 1'b1;
        if (state_q == StResp) rsp_valid[grant_id_q] = 1'b1;
    end

    assign mont_i_valid = (state_q == StIssue);
    assign mont_i_data  = {op_a_q, op_b_q, op_m_q};
    assign mont_o_ready = (state_q == StWait);
    assign rsp_data     = rsp_q;
    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_id_q;

    // Control FSM with operand, result and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_m_q     <= '0;
            rsp_q      <= '0;
`ifndef MONT_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        op_a_q     <= req_a[win_idx*MOD_WIDTH +: MOD_WIDTH];
                        op_b_q     <= req_b[win_idx*MOD_WIDTH +: MOD_WIDTH];
                        op_m_q     <= req_modulus[win_idx*MOD_WIDTH +: MOD_WIDTH];
                        grant_id_q <= win_idx;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (mont_i_ready) state_q <= StWait;
                end
                StWait: begin
                    if (mont_o_valid) begin
                        rsp_q   <= mont_o_data;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready[grant_id_q]) begin
                        state_q <= StIdle;
`ifndef MONT_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= (grant_id_q == IDW'(NUM_REQ - 1)) ? '0
                                                                        : grant_id_q + IDW'(1);
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_arbiter.sv
// Directed bench for mont_arbiter (MOD_WIDTH=8, NUM_REQ=3).
// A behavioural Montgomery stub returns a^b^modulus after LAT cycles.
// Each grant pushes its expected response to a queue; each response handshake pops and compares it.
module tb_mont_arbiter;
    localparam int unsigned MW  = 8;
    localparam int unsigned NR  = 3;
    localparam int          LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*MW-1:0]   req_a, req_b, req_modulus;
    logic [MW-1:0]      rsp_data, mont_o_data;
    logic               mont_i_valid, mont_i_ready, mont_o_valid, mont_o_ready, busy;
    logic [3*MW-1:0]    mont_i_data;
    logic [1:0]         grant_id;

    mont_arbiter #(.MOD_WIDTH(MW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_modulus(req_modulus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mont_i_valid(mont_i_valid), .mont_i_ready(mont_i_ready), .mont_i_data(mont_i_data),
        .mont_o_valid(mont_o_valid), .mont_o_ready(mont_o_ready), .mont_o_data(mont_o_data),
        .busy(busy), .grant_id(grant_id)
    );

    // Requesters: each one stays valid while issued ops outnumber granted ops
    int unsigned   issued  [NR] = '{0, 0, 0};
    int unsigned   granted [NR] = '{0, 0, 0};
    logic [MW-1:0] a_v [NR];
    logic [MW-1:0] b_v [NR];
    logic [MW-1:0] m_v [NR];

    always_comb begin
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_modulus = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = (issued[i] != granted[i]);
            req_a[i*MW +: MW]       = a_v[i];
            req_b[i*MW +: MW]       = b_v[i];
            req_modulus[i*MW +: MW] = m_v[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) granted[i] <= granted[i] + 1;
        end
    end

    // Montgomery stub
    logic    stub_busy;
    int      stub_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy    <= 1'b0;
            stub_cnt     <= 0;
            mont_o_valid <= 1'b0;
            mont_o_data  <= '0;
        end else if (mont_o_valid) begin
            if (mont_o_ready) mont_o_valid <= 1'b0;
        end else if (stub_busy) begin
            if (stub_cnt == 1) begin
                mont_o_valid <= 1'b1;
                stub_busy    <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (mont_i_valid && mont_i_ready) begin
            stub_busy   <= 1'b1;
            stub_cnt    <= LAT;
            mont_o_data <= mont_i_data[23:16] ^ mont_i_data[15:8] ^ mont_i_data[7:0];
        end
    end

    typedef struct packed {
        logic [1:0]    id;
        logic [MW-1:0] res;
    } exp_t;

    exp_t            sb[$];
    int              exp_order [12];
    int              gidx = 0;
    int              cyc = 0;
    int              resp_cyc = 0;
    bit              pend_at_resp = 1'b0;
    int              cur_w = 0;
    logic [3*MW-1:0] cur_ops = '0;
    int              checks = 0;
    int              failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observes the values the DUT presents at the coming rising edge
    task automatic monitor();
        if (req_ready != '0) begin
            int w = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) w = i;
            check("req_ready_onehot", 32'(req_ready), 32'(1) << w);
            check("grant_order", w, (gidx < 12) ? exp_order[gidx] : -1);
            check("grant_while_busy", 32'(busy), 0);
            if (pend_at_resp) check("grant_gap", cyc - resp_cyc, 1);
            pend_at_resp = 1'b0;
            cur_w   = w;
            cur_ops = {a_v[w], b_v[w], m_v[w]};
            sb.push_back('{id: 2'(w), res: a_v[w] ^ b_v[w] ^ m_v[w]});
            gidx++;
        end
        if (mont_i_valid) begin
            check("mont_i_data", 32'(mont_i_data), 32'(cur_ops));
            check("grant_id", 32'(grant_id), cur_w);
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                check("rsp_valid", 32'(rsp_valid), 32'(1) << sb[0].id);
                check("rsp_data", 32'(rsp_data), 32'(sb[0].res));
                if (rsp_ready[sb[0].id]) begin
                    void'(sb.pop_front());
                    resp_cyc     = cyc;
                    pend_at_resp = (req_valid != '0);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit all_done();
        bit d = !busy && (sb.size() == 0);
        for (int i = 0; i < NR; i++) if (issued[i] != granted[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        while (!all_done() && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(n < 200), 1);
    endtask

    // sel: 0 = mont_i_valid, 1 = any rsp_valid, 2 = waiting on the multiplier
    task automatic wait_for(input string tag, input int sel);
        int n = 0;
        bit hit = 1'b0;
        while (n < 50) begin
            hit = (sel == 0) ? mont_i_valid :
                  (sel == 1) ? (rsp_valid != '0) : mont_o_ready;
            if (hit) break;
            step();
            n++;
        end
        check(tag, 32'(hit), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        pend_at_resp = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef MONT_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1, 2, 1, 0, 2, 0, 2, 1, 0};
`else
        exp_order = '{0, 0, 1, 2, 0, 1, 0, 2, 0, 2, 1, 0};
`endif
        a_v = '{8'h5A, 8'h11, 8'hA0};
        b_v = '{8'h0F, 8'h22, 8'h0B};
        m_v = '{8'hC3, 8'h33, 8'h5C};
        rst_n        = 1'b0;
        mont_i_ready = 1'b1;
        rsp_ready    = '1;

        // Reset with every requester valid
        for (int i = 0; i < NR; i++) issued[i] = 1;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_mont_i_valid", 32'(mont_i_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_mont_o_ready", 32'(mont_o_ready), 0);
        for (int i = 0; i < NR; i++) issued[i] = 0;
        rst_n = 1'b1;
        step();

        // Single op from requester 0: 5A^0F^C3 = 96
        issued[0]++;
        wait_done("t2_done");
        check("t2_busy_low", 32'(busy), 0);

        // Continuous requests from all three (requester 0 twice)
        do_reset();
        issued[0] += 2;
        issued[1]++;
        issued[2]++;
        wait_done("t3_done");

        // Backpressure on the multiplier input, then on the response
        mont_i_ready = 1'b0;
        issued[1]++;
        wait_for("t4_issue", 0);
        issued[0]++;
        for (int i = 0; i < 5; i++) step();
        check("t4_issue_held", 32'(mont_i_valid), 1);
        rsp_ready    = 3'b101;
        mont_i_ready = 1'b1;
        wait_for("t4_rsp", 1);
        for (int i = 0; i < 3; i++) step();
        check("t4_rsp_held", 32'(rsp_valid), 32'b010);
        rsp_ready = '1;
        wait_done("t4_done");

        // Requester 2 completes while 0 and 2 are waiting
        issued[2]++;
        wait_for("t5_issue", 0);
        issued[0]++;
        issued[2]++;
        wait_done("t5_done");

        // Reset while waiting on the multiplier
        issued[1]++;
        wait_for("t6_wait", 2);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_rsp_valid", 32'(rsp_valid), 0);
        check("t6_mont_o_ready", 32'(mont_o_ready), 0);
        sb.delete();
        pend_at_resp = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("t6_quiet", 32'(busy), 0);
        a_v[0] = 8'h3C;
        issued[0]++;
        wait_done("t6_done");

        check("grant_count", gidx, 12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
